// File: rtl/ldtu_pkg.sv
// rtl/ldtu_pkg.sv - shared constants, state type and helpers for the LiTe-DTU sample packer
package ldtu_pkg;

  localparam int SAMPLE_BITS  = 13;
  localparam int BL_BITS      = 6;
  localparam int ACC_BITS     = 30;
  localparam int WORD_BITS    = 32;
  localparam int BL_PER_WORD  = 5;
  localparam int SIG_PER_WORD = 2;

  localparam logic [1:0] HDR_BL_FULL  = 2'b01;
  localparam logic [3:0] HDR_BL_PART  = 4'b0011;
  localparam logic [5:0] HDR_SIG_FULL = 6'b001010;
  localparam logic [5:0] HDR_SIG_PART = 6'b001011;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_ACC_BL  = 2'd1,
    ST_ACC_SIG = 2'd2
  } pack_state_t;

  // Places a 6-bit baseline sample into slot cnt; slot 0 is the oldest sample.
  function automatic logic [ACC_BITS-1:0] bl_insert(input logic [ACC_BITS-1:0] acc,
                                                    input logic [2:0] cnt,
                                                    input logic [BL_BITS-1:0] smp);
    logic [ACC_BITS-1:0] res;
    res = acc;
    case (cnt)
      3'd0:    res[5:0]   = smp;
      3'd1:    res[11:6]  = smp;
      3'd2:    res[17:12] = smp;
      3'd3:    res[23:18] = smp;
      default: res[29:24] = smp;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ldtu_sample_packer_if.sv
// rtl/ldtu_sample_packer_if.sv - sample input and word output bundle of the packer
interface ldtu_sample_packer_if;
  import ldtu_pkg::*;

  logic [SAMPLE_BITS-1:0] DATA_to_enc;
  logic                   baseline_flag;
  logic                   word_rd;
  logic [WORD_BITS-1:0]   word_out;
  logic                   word_avail;
  logic                   fifo_ovf;
  logic                   SeuError;

  modport slave (
    input  DATA_to_enc, baseline_flag, word_rd,
    output word_out, word_avail, fifo_ovf, SeuError
  );

  modport master (
    output DATA_to_enc, baseline_flag, word_rd,
    input  word_out, word_avail, fifo_ovf, SeuError
  );

endinterface

// File: rtl/ldtu_word_fifo.sv
// rtl/ldtu_word_fifo.sv - show-ahead 32-bit word FIFO with sticky overflow flag
module ldtu_word_fifo
  import ldtu_pkg::*;
#(
  parameter int FifoDepthW = 8,
  parameter int NBitsPtr   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_wr_en,
  input  logic [WORD_BITS-1:0] i_wr_data,
  input  logic                 i_rd_en,
  output logic [WORD_BITS-1:0] o_rd_data,
  output logic                 o_avail,
  output logic                 o_ovf
);

  logic [WORD_BITS-1:0] r_mem [FifoDepthW];
  logic [NBitsPtr:0]    r_wptr;
  logic [NBitsPtr:0]    r_rptr;
  logic                 r_ovf;

  logic w_empty;
  logic w_full;
  logic w_do_rd;
  logic w_do_wr;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[NBitsPtr] != r_rptr[NBitsPtr]) &&
                   (r_wptr[NBitsPtr-1:0] == r_rptr[NBitsPtr-1:0]);
  assign w_do_rd = i_rd_en && !w_empty;
  // A pop on the same edge frees the slot the incoming word lands in.
  assign w_do_wr = i_wr_en && (!w_full || w_do_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
      if (i_wr_en && !w_do_wr) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr[NBitsPtr-1:0]] <= i_wr_data;
  end

  assign o_rd_data = w_empty ? '0 : r_mem[r_rptr[NBitsPtr-1:0]];
  assign o_avail   = !w_empty;
  assign o_ovf     = r_ovf;

endmodule

// File: rtl/ldtu_sample_packer.sv
// rtl/ldtu_sample_packer.sv - packs 13-bit samples into 32-bit words (5 baseline or 2 signal per word)
module ldtu_sample_packer
  import ldtu_pkg::*;
#(
  parameter int FifoDepthW = 8,
  parameter int NBitsPtr   = 3
) (
  input  logic CLK,
  input  logic rst_b,
  ldtu_sample_packer_if.slave bus
);

  logic [SAMPLE_BITS-1:0] r_s_data;
  logic                   r_s_bl;
  logic                   r_s_vld;
  pack_state_t            r_state;
  logic [2:0]             r_cnt;
  logic [ACC_BITS-1:0]    r_acc;

  pack_state_t            w_state_nxt;
  logic [2:0]             w_cnt_nxt;
  logic [ACC_BITS-1:0]    w_acc_nxt;
  logic                   w_wr_en;
  logic [WORD_BITS-1:0]   w_wr_data;
  logic [ACC_BITS-1:0]    w_bl_first;
  logic [ACC_BITS-1:0]    w_sig_first;
  logic [WORD_BITS-1:0]   w_word_out;
  logic                   w_word_avail;
  logic                   w_fifo_ovf;

  // r_s_vld keeps the cleared input register from being packed as a real sample after reset.
  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      r_s_data <= '0;
      r_s_bl   <= 1'b0;
      r_s_vld  <= 1'b0;
      r_state  <= ST_EMPTY;
      r_cnt    <= '0;
      r_acc    <= '0;
    end else begin
      r_s_data <= bus.DATA_to_enc;
      r_s_bl   <= bus.baseline_flag;
      r_s_vld  <= 1'b1;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
    end
  end

  assign w_bl_first  = {{(ACC_BITS-BL_BITS){1'b0}}, r_s_data[BL_BITS-1:0]};
  assign w_sig_first = {{(ACC_BITS-SAMPLE_BITS){1'b0}}, r_s_data};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_wr_en     = 1'b0;
    w_wr_data   = '0;
    if (r_s_vld) begin
      case (r_state)
        ST_ACC_BL: begin
          if (!r_s_bl) begin
            w_wr_en     = 1'b1;
            w_wr_data   = {HDR_BL_PART, {1'b0, r_cnt}, r_acc[23:0]};
            w_acc_nxt   = w_sig_first;
            w_cnt_nxt   = 3'd1;
            w_state_nxt = ST_ACC_SIG;
          end else if (r_cnt == 3'(BL_PER_WORD - 1)) begin
            w_wr_en     = 1'b1;
            w_wr_data   = {HDR_BL_FULL, bl_insert(r_acc, r_cnt, r_s_data[BL_BITS-1:0])};
            w_acc_nxt   = '0;
            w_cnt_nxt   = 3'd0;
            w_state_nxt = ST_EMPTY;
          end else begin
            w_acc_nxt = bl_insert(r_acc, r_cnt, r_s_data[BL_BITS-1:0]);
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
        ST_ACC_SIG: begin
          if (r_s_bl) begin
            w_wr_en     = 1'b1;
            w_wr_data   = {HDR_SIG_PART, {SAMPLE_BITS{1'b0}}, r_acc[SAMPLE_BITS-1:0]};
            w_acc_nxt   = w_bl_first;
            w_cnt_nxt   = 3'd1;
            w_state_nxt = ST_ACC_BL;
          end else if (r_cnt == 3'(SIG_PER_WORD - 1)) begin
            w_wr_en     = 1'b1;
            w_wr_data   = {HDR_SIG_FULL, r_s_data, r_acc[SAMPLE_BITS-1:0]};
            w_acc_nxt   = '0;
            w_cnt_nxt   = 3'd0;
            w_state_nxt = ST_EMPTY;
          end else begin
            w_acc_nxt = w_sig_first;
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
        default: begin
          w_acc_nxt   = r_s_bl ? w_bl_first : w_sig_first;
          w_cnt_nxt   = 3'd1;
          w_state_nxt = r_s_bl ? ST_ACC_BL : ST_ACC_SIG;
        end
      endcase
    end
  end

  ldtu_word_fifo #(
    .FifoDepthW (FifoDepthW),
    .NBitsPtr   (NBitsPtr)
  ) u_word_fifo (
    .clk       (CLK),
    .rst_n     (rst_b),
    .i_wr_en   (w_wr_en),
    .i_wr_data (w_wr_data),
    .i_rd_en   (bus.word_rd),
    .o_rd_data (w_word_out),
    .o_avail   (w_word_avail),
    .o_ovf     (w_fifo_ovf)
  );

  assign bus.word_out   = w_word_out;
  assign bus.word_avail = w_word_avail;
  assign bus.fifo_ovf   = w_fifo_ovf;
  assign bus.SeuError   = 1'b0;

endmodule

// File: tb/tb_ldtu_sample_packer.sv
// tb/tb_ldtu_sample_packer.sv - directed scoreboard bench for ldtu_sample_packer
module tb_ldtu_sample_packer;

  logic CLK;
  logic rst_b;
  ldtu_sample_packer_if bus ();

  ldtu_sample_packer #(.FifoDepthW(8), .NBitsPtr(3)) dut (
    .CLK   (CLK),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] m_fifo [$];
  logic [12:0] m_vals [$];
  bit          m_ovf;
  bit          m_type_bl;
  bit          m_s_vld;
  logic [12:0] m_s_data;
  bit          m_s_bl;

  function automatic logic [31:0] mk_word(input bit full);
    logic [31:0] w;
    w = '0;
    if (m_type_bl) begin
      for (int i = 0; i < m_vals.size(); i++) w = w | (32'(m_vals[i][5:0]) << (6 * i));
      if (full) w[31:30] = 2'b01;
      else begin
        w[31:28] = 4'b0011;
        w[27:24] = 4'(m_vals.size());
      end
    end else if (full) begin
      w = {6'b001010, m_vals[1], m_vals[0]};
    end else begin
      w = {6'b001011, 13'h0, m_vals[0]};
    end
    return w;
  endfunction

  task automatic model_edge(input logic [12:0] d, input bit bl, input bit rd);
    logic [31:0] w;
    bit have_w, full, can_rd;
    have_w = 0;
    w = '0;
    if (m_s_vld) begin
      if (m_vals.size() != 0 && m_type_bl != m_s_bl) begin
        w = mk_word(1'b0);
        have_w = 1;
        m_vals.delete();
      end
      m_type_bl = m_s_bl;
      m_vals.push_back(m_s_data);
      if ((m_type_bl && m_vals.size() == 5) || (!m_type_bl && m_vals.size() == 2)) begin
        w = mk_word(1'b1);
        have_w = 1;
        m_vals.delete();
      end
    end
    full   = (m_fifo.size() == 8);
    can_rd = rd && (m_fifo.size() != 0);
    if (can_rd) void'(m_fifo.pop_front());
    if (have_w) begin
      if (!full || can_rd) m_fifo.push_back(w);
      else m_ovf = 1;
    end
    m_s_vld  = 1;
    m_s_data = d;
    m_s_bl   = bl;
  endtask

  task automatic check_outputs();
    logic        exp_av;
    logic [31:0] exp_out;
    exp_av  = (m_fifo.size() != 0);
    exp_out = exp_av ? m_fifo[0] : 32'h0;
    n_assert++;
    assert (bus.word_avail === exp_av) else begin
      n_fail++;
      $error("FAIL word_avail observed=%0b expected=%0b", bus.word_avail, exp_av);
    end
    n_assert++;
    assert (bus.word_out === exp_out) else begin
      n_fail++;
      $error("FAIL word_out observed=%h expected=%h", bus.word_out, exp_out);
    end
    n_assert++;
    assert (bus.fifo_ovf === m_ovf) else begin
      n_fail++;
      $error("FAIL fifo_ovf observed=%0b expected=%0b", bus.fifo_ovf, m_ovf);
    end
    n_assert++;
    assert (bus.SeuError === 1'b0) else begin
      n_fail++;
      $error("FAIL SeuError observed=%0b expected=0", bus.SeuError);
    end
  endtask

  task automatic expect_word(input string tag, input logic [31:0] exp);
    n_assert++;
    assert (bus.word_out === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, bus.word_out, exp);
    end
  endtask

  task automatic expect_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [12:0] d, input bit bl, input bit rd);
    bus.DATA_to_enc   = d;
    bus.baseline_flag = bl;
    bus.word_rd       = rd;
    @(posedge CLK);
    model_edge(d, bl, rd);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    #1;
    m_fifo.delete();
    m_vals.delete();
    m_ovf   = 0;
    m_s_vld = 0;
    check_outputs();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    rst_b = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(13'($urandom_range(0, 8191)), 1'b1, 1'b1);
  endtask

  initial begin
    rst_b             = 1'b0;
    bus.DATA_to_enc   = '0;
    bus.baseline_flag = 1'b0;
    bus.word_rd       = 1'b0;

    // All baseline: values 1..10 with upper bits scrambled to exercise the width rule.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step({7'h55, 6'(i)}, 1'b1, 1'b0);
      if (i == 5) expect_bit("bl_avail_after_5th", bus.word_avail, 1'b0);
      if (i == 6) begin
        expect_bit("bl_avail_2_edges", bus.word_avail, 1'b1);
        expect_word("bl_full_word1", 32'h4510_3081);
      end
    end
    step(13'h0001, 1'b1, 1'b0);
    step(13'h0002, 1'b1, 1'b1);
    expect_word("bl_full_word2", 32'h4A24_81C6);
    drain(8);

    // All signal.
    do_reset();
    step(13'h1ABC, 1'b0, 1'b0);
    step(13'h0123, 1'b0, 1'b0);
    step(13'h0000, 1'b1, 1'b0);
    expect_word("sig_full_word", 32'h2824_7ABC);
    drain(6);

    // Type transitions emit partial words.
    do_reset();
    for (int i = 0; i < 3; i++) step(13'h1FBF, 1'b1, 1'b0);
    step(13'h1FFF, 1'b0, 1'b0);
    step(13'h0005, 1'b1, 1'b0);
    expect_word("bl_partial_word", 32'h3303_FFFF);
    step(13'h0006, 1'b1, 1'b1);
    expect_word("sig_partial_word", 32'h2C00_1FFF);
    drain(6);

    // Overflow: one word per edge with no reads.
    do_reset();
    for (int i = 0; i < 14; i++) step(13'($urandom_range(0, 8191)), i[0], 1'b0);
    expect_bit("ovf_set", bus.fifo_ovf, 1'b1);
    drain(14);
    expect_bit("ovf_sticky", bus.fifo_ovf, 1'b1);

    // Full FIFO with simultaneous read and write.
    do_reset();
    for (int i = 0; i < 10; i++) step(13'($urandom_range(0, 8191)), i[0], 1'b0);
    expect_bit("full_ovf_before", bus.fifo_ovf, 1'b0);
    step(13'($urandom_range(0, 8191)), 1'b0, 1'b1);
    expect_bit("full_rw_no_ovf", bus.fifo_ovf, 1'b0);
    drain(12);
    expect_bit("full_rw_ovf_end", bus.fifo_ovf, 1'b0);

    // Reset in the middle of a baseline word.
    do_reset();
    step(13'h0111, 1'b0, 1'b0);
    step(13'h0222, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(13'h002A, 1'b1, 1'b0);
    expect_bit("pre_reset_avail", bus.word_avail, 1'b1);
    do_reset();
    expect_bit("reset_avail_zero", bus.word_avail, 1'b0);
    for (int i = 7; i <= 11; i++) step(13'(i), 1'b1, 1'b0);
    step(13'h0333, 1'b0, 1'b0);
    expect_word("post_reset_word", 32'h4B28_9207);
    drain(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
